// File: rtl/i2c_byte_cmd_seq.sv
// I2C byte command sequencer: expands register-block byte requests
// into START / data / ACK / STOP bit commands for the bit engine.
module i2c_byte_cmd_seq #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  ena_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  read_i,
  input  logic                  write_i,
  input  logic                  ack_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic                  cmd_ack_o,
  output logic                  ack_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  i2c_al_o,
  output logic [3:0]            bit_cmd_o,
  output logic                  bit_txd_o,
  input  logic                  bit_ack_i,
  input  logic                  bit_rxd_i,
  input  logic                  bit_al_i
);

  localparam logic [3:0] CMD_NOP   = 4'b0000;
  localparam logic [3:0] CMD_START = 4'b0001;
  localparam logic [3:0] CMD_STOP  = 4'b0010;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_READ  = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WRITE,
    ST_READ,
    ST_ACK,
    ST_STOP
  } state_t;

  state_t                state_q, state_n;
  logic [3:0]            cmd_n;
  logic                  txd_n;
  logic                  done_n;
  logic                  ack_n;
  logic [DATA_WIDTH-1:0] dat_n;
  logic [DATA_WIDTH-1:0] shift;
  logic [2:0]            cnt_q, cnt_n;
  logic                  rd_q, rd_n;
  logic                  req;

  assign i2c_al_o = bit_al_i;
  assign shift    = {dat_o[DATA_WIDTH-2:0], bit_rxd_i};
  assign req      = start_i | stop_i | read_i | write_i;

  always_comb begin
    state_n = state_q;
    cmd_n   = bit_cmd_o;
    txd_n   = bit_txd_o;
    done_n  = 1'b0;
    ack_n   = ack_o;
    dat_n   = dat_o;
    cnt_n   = cnt_q;
    rd_n    = rd_q;
    // Arbitration loss or disable drops the byte silently.
    if (bit_al_i || !ena_i) begin
      state_n = ST_IDLE;
      cmd_n   = CMD_NOP;
      txd_n   = 1'b0;
      cnt_n   = 3'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (req && !cmd_ack_o) begin
            dat_n = dat_i;
            cnt_n = 3'd7;
            rd_n  = read_i;
            txd_n = 1'b0;
            priority case (1'b1)
              start_i: begin
                state_n = ST_START;
                cmd_n   = CMD_START;
              end
              read_i: begin
                state_n = ST_READ;
                cmd_n   = CMD_READ;
              end
              write_i: begin
                state_n = ST_WRITE;
                cmd_n   = CMD_WRITE;
                txd_n   = dat_i[DATA_WIDTH-1];
              end
              default: begin
                state_n = ST_STOP;
                cmd_n   = CMD_STOP;
              end
            endcase
          end
        end
        ST_START: begin
          if (bit_ack_i) begin
            if (rd_q) begin
              state_n = ST_READ;
              cmd_n   = CMD_READ;
              txd_n   = 1'b0;
            end else begin
              state_n = ST_WRITE;
              cmd_n   = CMD_WRITE;
              txd_n   = dat_o[DATA_WIDTH-1];
            end
          end
        end
        ST_WRITE, ST_READ: begin
          if (bit_ack_i) begin
            dat_n = shift;
            if (cnt_q == 3'd0) begin
              state_n = ST_ACK;
              cmd_n   = rd_q ? CMD_WRITE : CMD_READ;
              txd_n   = rd_q ? ack_i : 1'b0;
            end else begin
              cnt_n = cnt_q - 3'd1;
              txd_n = rd_q ? 1'b0 : shift[DATA_WIDTH-1];
            end
          end
        end
        ST_ACK: begin
          if (bit_ack_i) begin
            ack_n = bit_rxd_i;
            txd_n = 1'b0;
            if (stop_i) begin
              state_n = ST_STOP;
              cmd_n   = CMD_STOP;
            end else begin
              state_n = ST_IDLE;
              cmd_n   = CMD_NOP;
              done_n  = 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (bit_ack_i) begin
            state_n = ST_IDLE;
            cmd_n   = CMD_NOP;
            txd_n   = 1'b0;
            done_n  = 1'b1;
          end
        end
        default: begin
          state_n = ST_IDLE;
          cmd_n   = CMD_NOP;
          txd_n   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      bit_cmd_o <= CMD_NOP;
      bit_txd_o <= 1'b0;
      cmd_ack_o <= 1'b0;
      ack_o     <= 1'b0;
      dat_o     <= '0;
      cnt_q     <= 3'd0;
      rd_q      <= 1'b0;
    end else begin
      state_q   <= state_n;
      bit_cmd_o <= cmd_n;
      bit_txd_o <= txd_n;
      cmd_ack_o <= done_n;
      ack_o     <= ack_n;
      dat_o     <= dat_n;
      cnt_q     <= cnt_n;
      rd_q      <= rd_n;
    end
  end

endmodule

// File: tb/tb_i2c_byte_cmd_seq.sv
// Bench for i2c_byte_cmd_seq: table vectors, random byte requests
// against a sequence-level model, and abort / reset corner cases.
module tb_i2c_byte_cmd_seq;

  localparam logic [3:0] NOP = 4'b0000;
  localparam logic [3:0] STA = 4'b0001;
  localparam logic [3:0] STO = 4'b0010;
  localparam logic [3:0] WR  = 4'b0100;
  localparam logic [3:0] RD  = 4'b1000;

  logic       clk = 1'b0;
  logic       rst_n_i;
  logic       ena_i, start_i, stop_i, read_i, write_i, ack_i;
  logic [7:0] dat_i;
  logic       cmd_ack_o, ack_o, i2c_al_o, bit_txd_o;
  logic [7:0] dat_o;
  logic [3:0] bit_cmd_o;
  logic       bit_ack_i, bit_rxd_i, bit_al_i;

  always #5 clk = ~clk;

  i2c_byte_cmd_seq #(.DATA_WIDTH(8)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n_i),
    .ena_i    (ena_i),
    .start_i  (start_i),
    .stop_i   (stop_i),
    .read_i   (read_i),
    .write_i  (write_i),
    .ack_i    (ack_i),
    .dat_i    (dat_i),
    .cmd_ack_o(cmd_ack_o),
    .ack_o    (ack_o),
    .dat_o    (dat_o),
    .i2c_al_o (i2c_al_o),
    .bit_cmd_o(bit_cmd_o),
    .bit_txd_o(bit_txd_o),
    .bit_ack_i(bit_ack_i),
    .bit_rxd_i(bit_rxd_i),
    .bit_al_i (bit_al_i)
  );

  typedef struct {
    logic       sta;
    logic       sto;
    logic       rd;
    logic       wr;
    logic       ack;
    logic [7:0] dat;
    logic [7:0] rx;
    logic       rx_ack;
    int         dly;
    logic [7:0] e_dat;
    logic       e_ack;
    int         e_hs;
  } vec_t;

  vec_t       vt[6];
  logic [4:0] exp_q[$];
  logic [4:0] obs_q[$];
  int         checks = 0;
  int         errors = 0;
  logic       m_ack;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Expected {bit_cmd, txd} list for one byte request.
  task automatic build_exp(input vec_t v);
    exp_q.delete();
    if (!v.sta && !v.rd && !v.wr) begin
      exp_q.push_back({STO, 1'b0});
      return;
    end
    if (v.sta) exp_q.push_back({STA, 1'b0});
    for (int i = 7; i >= 0; i--)
      exp_q.push_back(v.rd ? {RD, 1'b0} : {WR, v.dat[i]});
    exp_q.push_back(v.rd ? {WR, v.ack} : {RD, 1'b0});
    if (v.sto) exp_q.push_back({STO, 1'b0});
  endtask

  task automatic clr_req();
    start_i = 1'b0;
    stop_i  = 1'b0;
    read_i  = 1'b0;
    write_i = 1'b0;
  endtask

  task automatic hs(input logic rxd);
    bit_ack_i = 1'b1;
    bit_rxd_i = rxd;
    @(posedge clk); #1;
    bit_ack_i = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, input string tag, input bit tab);
    logic [7:0] m_dat;
    logic       rxd;
    logic       byte_op;
    int         k;
    int         n;
    build_exp(v);
    byte_op = v.sta | v.rd | v.wr;
    m_dat   = byte_op ? v.rx : v.dat;
    if (byte_op) m_ack = v.rx_ack;
    obs_q.delete();
    k = 0;
    n = 0;
    start_i = v.sta;
    stop_i  = v.sto;
    read_i  = v.rd;
    write_i = v.wr;
    ack_i   = v.ack;
    dat_i   = v.dat;
    @(posedge clk); #1;
    while (bit_cmd_o != NOP && n < 20) begin
      obs_q.push_back({bit_cmd_o, bit_txd_o});
      repeat (v.dly) begin @(posedge clk); #1; end
      if (bit_cmd_o == RD || bit_cmd_o == WR) begin
        rxd = (k < 8) ? v.rx[7-k] : v.rx_ack;
        k++;
      end else begin
        rxd = 1'($urandom);
      end
      hs(rxd);
      n++;
    end
    chk({tag, " done"}, 32'(cmd_ack_o), 32'd1);
    @(posedge clk); #1;
    chk({tag, " pulse"}, 32'(cmd_ack_o), 32'd0);
    chk({tag, " reaccept"}, 32'(bit_cmd_o), 32'(NOP));
    clr_req();
    chk({tag, " hs"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("%s seq%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    chk({tag, " dat"}, 32'(dat_o), 32'(m_dat));
    chk({tag, " ack"}, 32'(ack_o), 32'(m_ack));
    if (tab) begin
      chk({tag, " tab hs"}, obs_q.size(), v.e_hs);
      chk({tag, " tab dat"}, 32'(dat_o), 32'(v.e_dat));
      chk({tag, " tab ack"}, 32'(ack_o), 32'(v.e_ack));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t       v;
    logic [7:0] d;
    logic [7:0] e;

    vt[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 8'hA5, 1'b0, 3,
              8'hA5, 1'b0, 11};
    vt[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'hCB, 1'b1, 1,
              8'hCB, 1'b1, 9};
    vt[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h00, 1'b0, 2,
              8'h3C, 1'b1, 1};
    vt[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 8'h5A, 1'b1, 0,
              8'h5A, 1'b1, 9};
    vt[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h11, 8'h96, 1'b0, 1,
              8'h96, 1'b0, 10};
    vt[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h0F, 8'h0F, 1'b1, 2,
              8'h0F, 1'b1, 11};

    rst_n_i   = 1'b0;
    ena_i     = 1'b1;
    ack_i     = 1'b0;
    dat_i     = 8'h00;
    bit_ack_i = 1'b0;
    bit_rxd_i = 1'b0;
    bit_al_i  = 1'b0;
    clr_req();
    m_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst cmd", 32'(bit_cmd_o), 32'(NOP));
    chk("rst txd", 32'(bit_txd_o), 32'd0);
    chk("rst done", 32'(cmd_ack_o), 32'd0);
    chk("rst ack", 32'(ack_o), 32'd0);
    chk("rst dat", 32'(dat_o), 32'd0);
    chk("rst al", 32'(i2c_al_o), 32'd0);
    rst_n_i = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++)
      run_txn(vt[i], $sformatf("vec%0d", i), 1'b1);

    // Arbitration lost together with the 4th data WRITE ack.
    d = 8'hC3;
    start_i = 1'b1;
    write_i = 1'b1;
    stop_i  = 1'b1;
    dat_i   = d;
    @(posedge clk); #1;
    hs(1'b0);
    hs(1'b1);
    hs(1'b1);
    hs(1'b1);
    chk("al 4th cmd", 32'(bit_cmd_o), 32'(WR));
    bit_ack_i = 1'b1;
    bit_al_i  = 1'b1;
    clr_req();
    #1;
    chk("al comb", 32'(i2c_al_o), 32'd1);
    @(posedge clk); #1;
    bit_ack_i = 1'b0;
    bit_al_i  = 1'b0;
    e = {d[4:0], 3'b111};
    chk("al cmd", 32'(bit_cmd_o), 32'(NOP));
    chk("al done", 32'(cmd_ack_o), 32'd0);
    chk("al dat", 32'(dat_o), 32'(e));
    chk("al ack", 32'(ack_o), 32'(m_ack));
    @(posedge clk); #1;
    chk("al idle", 32'(bit_cmd_o), 32'(NOP));
    chk("al done2", 32'(cmd_ack_o), 32'd0);

    // Enable dropped in the middle of a read.
    d = 8'h5C;
    read_i = 1'b1;
    dat_i  = d;
    @(posedge clk); #1;
    chk("ena rd cmd", 32'(bit_cmd_o), 32'(RD));
    hs(1'b1);
    hs(1'b0);
    ena_i = 1'b0;
    clr_req();
    @(posedge clk); #1;
    e = {d[5:0], 2'b10};
    chk("ena cmd", 32'(bit_cmd_o), 32'(NOP));
    chk("ena done", 32'(cmd_ack_o), 32'd0);
    chk("ena dat", 32'(dat_o), 32'(e));
    ena_i = 1'b1;
    @(posedge clk); #1;
    chk("ena idle", 32'(bit_cmd_o), 32'(NOP));

    // Reset pulse mid-write, with a bit ack pending on the same edge.
    write_i = 1'b1;
    dat_i   = 8'h77;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) hs(1'b1);
    rst_n_i   = 1'b0;
    bit_ack_i = 1'b1;
    clr_req();
    @(posedge clk); #1;
    rst_n_i   = 1'b1;
    bit_ack_i = 1'b0;
    m_ack     = 1'b0;
    chk("mrst cmd", 32'(bit_cmd_o), 32'(NOP));
    chk("mrst txd", 32'(bit_txd_o), 32'd0);
    chk("mrst done", 32'(cmd_ack_o), 32'd0);
    chk("mrst ack", 32'(ack_o), 32'd0);
    chk("mrst dat", 32'(dat_o), 32'd0);
    run_txn(vt[3], "post rst", 1'b1);

    for (int i = 0; i < 40; i++) begin
      v.sta    = 1'($urandom);
      v.sto    = 1'($urandom);
      v.rd     = 1'($urandom);
      v.wr     = 1'($urandom);
      v.ack    = 1'($urandom);
      v.dat    = 8'($urandom);
      v.rx     = 8'($urandom);
      v.rx_ack = 1'($urandom);
      v.dly    = int'($urandom_range(0, 2));
      v.e_dat  = 8'h00;
      v.e_ack  = 1'b0;
      v.e_hs   = 0;
      if (!(v.sta | v.sto | v.rd | v.wr)) v.wr = 1'b1;
      run_txn(v, $sformatf("rnd%0d", i), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
